// File: rtl/piso_pkg.sv
// Shared types and constants for the 16-bit PISO framer.
// Optional build macro: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

`ifdef PISO_PARITY_EN
    localparam int LAST_IDX = 16;
    localparam int CNT_W    = 5;
`else
    localparam int LAST_IDX = 15;
    localparam int CNT_W    = 4;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_16_1.sv
// 16:1 bit multiplexer used by the PISO framer to pick the outgoing bit.
module mux_16_1
    import piso_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);

    // Select one bit of the input word
    always_comb out = in[sel];

endmodule

// File: rtl/piso_serializer_16.sv
// Parallel-in/serial-out framer: accepts a 16-bit word over valid/ready and
// steps the mux select once per clock, framing the stream with valid,
// start and done strobes. Pause freezes the stream in place.
// Optional build macro: PISO_PARITY_EN adds a 17th even-parity bit.
module piso_serializer_16
    import piso_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              msb_first,
    input  logic              pause,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic [SEL_W-1:0]  sel
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_q;
    logic              dir_q;

    logic              active;
    logic              last_bit;
    logic              accept;
    logic              mux_out;
    logic [SEL_W-1:0]  sel_c;

    mux_16_1 u_mux (
        .in  (data_q),
        .sel (sel_c),
        .out (mux_out)
    );

    // Handshake and frame-position decode from registered state
    always_comb begin
        active     = (state == SHIFT) && !rst;
        last_bit   = (cnt == CNT_W'(LAST_IDX));
        load_ready = !rst && ((state == IDLE) ||
                              ((state == SHIFT) && last_bit && !pause));
        accept     = load_valid && load_ready;
    end

    // Mux select: counts up for LSB-first, down (15-cnt == ~cnt) for MSB-first
    always_comb begin
        sel_c = '0;
        if (state == SHIFT) begin
            sel_c = dir_q ? ~cnt[SEL_W-1:0] : cnt[SEL_W-1:0];
`ifdef PISO_PARITY_EN
            // Parity slot keeps the select parked on the last data bit
            if (cnt == CNT_W'(DATA_W))
                sel_c = dir_q ? '0 : '1;
`endif
        end
    end

    // Serial outputs and strobes; all forced low while reset is held
    always_comb begin
        sel         = active ? sel_c : '0;
        ser_out     = active ? mux_out : 1'b0;
`ifdef PISO_PARITY_EN
        if (active && (cnt == CNT_W'(DATA_W)))
            ser_out = ^data_q;
`endif
        ser_valid   = active && !pause;
        frame_start = active && !pause && (cnt == '0);
        frame_done  = active && !pause && last_bit;
    end

    // Frame FSM: capture on accept, advance unless paused, reload or idle at end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= load_data;
                        dir_q  <= msb_first;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!pause) begin
                        if (last_bit) begin
                            cnt <= '0;
                            if (accept) begin
                                data_q <= load_data;
                                dir_q  <= msb_first;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
